// File: rtl/data_ram256x8.sv
// ============================================================================
// data_ram256x8 : 256 x 8 byte-addressed big-endian RAM, byte/half/word access
// Rev 1.0
// ============================================================================
`default_nettype none

module data_ram256x8 (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] DataOut,
  input  logic        ReadWrite,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  input  logic [1:0]  Size
);

  localparam logic [1:0] C_SIZE_BYTE = 2'b00;
  localparam logic [1:0] C_SIZE_HALF = 2'b01;
  localparam logic [1:0] C_SIZE_WORD = 2'b10;

  logic [7:0]  Mem [0:255];

  // Declaration initialiser gives a zero output before the first clock edge.
  logic [31:0] data_out_q = 32'h0000_0000;
  logic [31:0] data_out_d;

  logic [7:0]  lane_addr  [4];
  logic [7:0]  lane_wdata [4];
  logic [3:0]  lane_we;

  logic        unused_addr_hi;
  assign unused_addr_hi = ^Address[31:8];

  // Lane k addresses byte A+k; 8-bit arithmetic wraps modulo 256.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = Address[7:0] + 8'(k);
    end
  end

  always_comb begin
    data_out_d    = data_out_q;
    lane_we       = 4'b0000;
    lane_wdata[0] = 8'h00;
    lane_wdata[1] = 8'h00;
    lane_wdata[2] = 8'h00;
    lane_wdata[3] = 8'h00;

    if (reset) begin
      data_out_d = 32'h0000_0000;
    end else if (ReadWrite) begin
      case (Size)
        C_SIZE_BYTE: begin
          lane_we       = 4'b0001;
          lane_wdata[0] = DataIn[7:0];
        end
        C_SIZE_HALF: begin
          lane_we       = 4'b0011;
          lane_wdata[0] = DataIn[15:8];
          lane_wdata[1] = DataIn[7:0];
        end
        C_SIZE_WORD: begin
          lane_we       = 4'b1111;
          lane_wdata[0] = DataIn[31:24];
          lane_wdata[1] = DataIn[23:16];
          lane_wdata[2] = DataIn[15:8];
          lane_wdata[3] = DataIn[7:0];
        end
        default: lane_we = 4'b0000;
      endcase
    end else begin
      case (Size)
        C_SIZE_BYTE: data_out_d = {24'h000000, Mem[lane_addr[0]]};
        C_SIZE_HALF: data_out_d = {16'h0000, Mem[lane_addr[0]], Mem[lane_addr[1]]};
        C_SIZE_WORD: data_out_d = {Mem[lane_addr[0]], Mem[lane_addr[1]],
                                   Mem[lane_addr[2]], Mem[lane_addr[3]]};
        default:     data_out_d = 32'h0000_0000;
      endcase
    end
  end

  // Memory is deliberately outside the reset domain so preloads survive reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (lane_we[k]) begin
        Mem[lane_addr[k]] <= lane_wdata[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    data_out_q <= data_out_d;
  end

  assign DataOut = data_out_q;

endmodule

`default_nettype wire

// File: tb/tb_data_ram256x8.sv
// ============================================================================
// tb_data_ram256x8 : directed self-checking bench for data_ram256x8
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_data_ram256x8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] DataOut;
  logic        ReadWrite;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [1:0]  Size;

  int n_tests = 0;
  int n_fail  = 0;

  data_ram256x8 dut (
    .clk       (clk),
    .reset     (reset),
    .DataOut   (DataOut),
    .ReadWrite (ReadWrite),
    .Address   (Address),
    .DataIn    (DataIn),
    .Size      (Size)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one operation on the falling edge, then sample 1 time unit after the rising edge.
  task automatic op(input logic rst, input logic rw, input logic [31:0] addr,
                    input logic [31:0] din, input logic [1:0] sz);
    @(negedge clk);
    reset     = rst;
    ReadWrite = rw;
    Address   = addr;
    DataIn    = din;
    Size      = sz;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    ReadWrite = 1'b0;
    Address   = 32'h0;
    DataIn    = 32'h0;
    Size      = 2'b10;

    #1;
    check("out_before_clk", DataOut, 32'h0);

    for (int i = 0; i < 16; i++) dut.Mem[i] = 8'h00;
    dut.Mem[0] = 8'h11; dut.Mem[1] = 8'h22; dut.Mem[2] = 8'h33; dut.Mem[3] = 8'h44;
    dut.Mem[4] = 8'h55; dut.Mem[5] = 8'h66; dut.Mem[6] = 8'h77; dut.Mem[7] = 8'h88;

    op(1'b1, 1'b0, 32'h0, 32'h0, 2'b10);
    check("reset_out", DataOut, 32'h0);

    // Basic reads of each size
    op(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
    check("word_rd_0", DataOut, 32'h11223344);
    op(1'b0, 1'b0, 32'h4, 32'h0, 2'b10);
    check("word_rd_4", DataOut, 32'h55667788);
    op(1'b0, 1'b0, 32'h1, 32'h0, 2'b00);
    check("byte_rd_1", DataOut, 32'h00000022);
    op(1'b0, 1'b0, 32'h2, 32'h0, 2'b01);
    check("half_rd_2", DataOut, 32'h00003344);
    op(1'b0, 1'b0, 32'h0, 32'h0, 2'b11);
    check("rsvd_rd", DataOut, 32'h0);

    // Reserved-size write leaves memory alone
    op(1'b0, 1'b1, 32'h0, 32'hDEADBEEF, 2'b11);
    op(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
    check("rsvd_wr_nochg", DataOut, 32'h11223344);

    // Inputs moving between edges have no effect
    #2 Address = 32'h4;
    #1 check("between_edges", DataOut, 32'h11223344);

    // Byte then halfword write; DataOut held during writes
    op(1'b0, 1'b1, 32'h0, 32'h000000B5, 2'b00);
    check("byte_wr_hold", DataOut, 32'h11223344);
    op(1'b0, 1'b1, 32'h2, 32'h0000FFD3, 2'b01);
    op(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
    check("rd_after_bh_wr", DataOut, 32'hB522FFD3);

    op(1'b0, 1'b1, 32'h8, 32'hE35D8AC5, 2'b10);
    op(1'b0, 1'b0, 32'h8, 32'h0, 2'b10);
    check("word_wr_rd_8", DataOut, 32'hE35D8AC5);
    check("mem8", {24'h0, dut.Mem[8]}, 32'h000000E3);
    check("mem12_untouched", {24'h0, dut.Mem[12]}, 32'h0);

    // Wrap-around
    @(negedge clk);
    dut.Mem[254] = 8'hAA; dut.Mem[255] = 8'hBB; dut.Mem[0] = 8'hCC; dut.Mem[1] = 8'hDD;
    op(1'b0, 1'b0, 32'hFE, 32'h0, 2'b10);
    check("wrap_rd_fe", DataOut, 32'hAABBCCDD);
    op(1'b0, 1'b0, 32'h1FE, 32'h0, 2'b10);
    check("wrap_rd_1fe", DataOut, 32'hAABBCCDD);
    op(1'b0, 1'b1, 32'hFF, 32'h01020304, 2'b10);
    op(1'b0, 1'b0, 32'hFF, 32'h0, 2'b10);
    check("wrap_wr_rd_ff", DataOut, 32'h01020304);
    check("mem254_untouched", {24'h0, dut.Mem[254]}, 32'h000000AA);

    // Reset with concurrent write is suppressed and memory kept
    @(negedge clk);
    dut.Mem[0] = 8'h11; dut.Mem[1] = 8'h22; dut.Mem[2] = 8'h33; dut.Mem[3] = 8'h44;
    op(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
    check("pre_reset_rd", DataOut, 32'h11223344);
    op(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 2'b10);
    check("reset_cycle_out", DataOut, 32'h0);
    op(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
    check("post_reset_rd", DataOut, 32'h11223344);

    // Write hold then immediate read-back
    op(1'b0, 1'b0, 32'h4, 32'h0, 2'b10);
    check("rd_4_again", DataOut, 32'h55667788);
    op(1'b0, 1'b1, 32'h4, 32'hCAFEBABE, 2'b10);
    check("word_wr_hold", DataOut, 32'h55667788);
    op(1'b0, 1'b0, 32'h4, 32'h0, 2'b10);
    check("raw_4", DataOut, 32'hCAFEBABE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
